// File: rtl/ram_be_pipelined.sv
// Simple-dual-port RAM with byte enables, READ_LAT-stage read pipeline and post-reset clear.
// Optional macro RAM_BYPASS_EN: same-address write forwards merged data to a concurrent read.
module ram_be_pipelined #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR     = $clog2(DEPTH),
    parameter int READ_LAT = 1,
    localparam int NBE     = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [ADDR-1:0]  wr_addr,
    input  logic [NBE-1:0]   wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [ADDR-1:0]  rd_addr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             init_busy,
    output logic             err_addr
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]          r_state;
    logic [ADDR-1:0]     r_clr_cnt;
    logic                r_err;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [READ_LAT-1:0] r_vld;
    logic [WIDTH-1:0]    r_data [READ_LAT];

    logic                w_run;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_wr_inr;
    logic                w_rd_inr;
    logic [WIDTH-1:0]    w_rd_word;

    assign w_run    = (r_state == S_RUN);
    assign w_wr_acc = wr_en & w_run;
    assign w_rd_acc = rd_en & w_run;
    assign w_wr_inr = (32'(wr_addr) < 32'(DEPTH));
    assign w_rd_inr = (32'(rd_addr) < 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == ADDR'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    if ((w_wr_acc && !w_wr_inr) || (w_rd_acc && !w_rd_inr)) begin
                        r_err <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset: the clear sequence zeroes it word by word instead.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_acc && w_wr_inr) begin
            for (int unsigned i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_inr) begin
            w_rd_word = r_mem[rd_addr];
        end
`ifdef RAM_BYPASS_EN
        if (w_wr_acc && w_wr_inr && (wr_addr == rd_addr)) begin
            for (int unsigned i = 0; i < NBE; i++) begin
                if (wr_be[i]) begin
                    w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
`endif
    end

    // Each stage loads only behind a valid, so the last stage holds between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_data[0] <= w_rd_word;
            end
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign rd_valid  = r_vld[READ_LAT-1];
    assign rd_data   = r_data[READ_LAT-1];
    assign init_busy = (r_state == S_CLEAR);
    assign err_addr  = r_err;

endmodule

// File: tb/tb_ram_be_pipelined.sv
// Bench for ram_be_pipelined: directed vector table, reset corner sequences, and random traffic
// checked cycle by cycle against an array/queue reference model.
module tb_ram_be_pipelined;

    localparam int WIDTH = 32;
    localparam int DEPTH = 12;
    localparam int ADDR  = 4;
    localparam int RL    = 3;

`ifdef RAM_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             wr_en   = 1'b0;
    logic [ADDR-1:0]  wr_addr = '0;
    logic [3:0]       wr_be   = '0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en   = 1'b0;
    logic [ADDR-1:0]  rd_addr = '0;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             init_busy;
    logic             err_addr;

    ram_be_pipelined #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ADDR(ADDR),
        .READ_LAT(RL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_be(wr_be),
        .wr_data(wr_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .init_busy(init_busy),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: word array, queue of pending read results keyed by due cycle.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic [31:0] m_mem [DEPTH];
    rd_t         m_q[$];
    int          cyc        = 0;
    int          m_clr_left = 0;
    logic        m_err      = 1'b0;
    logic [31:0] m_hold     = '0;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        re;
        logic [3:0]  ra;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mask = mask | (32'h0000_00FF << (8 * i));
        end
        return (old & ~mask) | (wd & mask);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_hold     = '0;
        m_err      = 1'b0;
        m_clr_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic model_edge(input logic we, input logic [3:0] wa, input logic [3:0] be,
                              input logic [31:0] wd, input logic re, input logic [3:0] ra);
        logic [31:0] d;
        cyc++;
        if (m_clr_left > 0) begin
            m_clr_left--;
        end else begin
            if (re) begin
                d = '0;
                if (int'(ra) < DEPTH) d = m_mem[ra];
                else m_err = 1'b1;
`ifdef RAM_BYPASS_EN
                if (we && (wa == ra) && (int'(wa) < DEPTH)) d = merge(m_mem[ra], wd, be);
`endif
                m_q.push_back('{due: cyc + RL - 1, data: d});
            end
            if (we) begin
                if (int'(wa) < DEPTH) m_mem[wa] = merge(m_mem[wa], wd, be);
                else m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic ev;
        ev = 1'b0;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            ev     = 1'b1;
            m_hold = m_q[0].data;
            void'(m_q.pop_front());
        end
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        chk("rd_data", rd_data, m_hold);
        chk("init_busy", 32'(init_busy), 32'(m_clr_left > 0));
        chk("err_addr", 32'(err_addr), 32'(m_err));
    endtask

    task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic re, input logic [3:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_be   = be;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        model_edge(we, wa, be, wd, re, ra);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    endtask

    task automatic rand_step();
        step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    endtask

    task automatic do_reset(input int hold);
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        model_reset();
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
        chk("rst_init_busy", 32'(init_busy), 32'd1);
        repeat (hold) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Requests during the clear are random and must be ignored.
    task automatic wait_clear();
        int n;
        n = 0;
        if (init_busy) n = 1;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            rand_step();
            if (!init_busy) break;
            n++;
        end
        chk("busy_len", 32'(n), 32'(DEPTH));
    endtask

    task automatic add(input logic we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra,
                       input logic ev, input logic [31:0] ed, input logic ee);
        vq.push_back('{we: we, wa: wa, be: be, wd: wd, re: re, ra: ra, ev: ev, ed: ed, ee: ee});
    endtask

    initial begin
        // Rows: inputs for one cycle, then outputs expected right after that edge.
        add(1, 3, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0, 0);
        add(1, 3, 4'b0101, 32'h11223344, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 32'hAA22CC44, 0);
        for (int a = 0; a < 5; a++) add(1, 4'(a), 4'hF, 32'(a) * 32'h01010101, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 2, 1, 32'h00000000, 0);
        add(0, 0, 0, 0, 1, 3, 1, 32'h01010101, 0);
        add(0, 0, 0, 0, 1, 4, 1, 32'h02020202, 0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h03030303, 0);
        add(0, 0, 0, 0, 0, 0, 1, 32'h04040404, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 5, 4'hF, 32'hDEADBEEF, 1, 5, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, COLL_EXP, 0);
        add(1, 13, 4'hF, 32'h12345678, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 13, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 32'h00000000, 1);
        add(0, 0, 0, 0, 1, 5, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1);
        add(0, 0, 0, 0, 0, 0, 1, 32'h01010101, 1);
        add(1, 1, 4'h0, 32'hFFFFFFFF, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1, 32'h01010101, 1);

        #3;
        do_reset(2);
        wait_clear();
        for (int a = 0; a < DEPTH; a++) step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
        repeat (RL + 1) idle();

        foreach (vq[i]) begin
            step(vq[i].we, vq[i].wa, vq[i].be, vq[i].wd, vq[i].re, vq[i].ra);
            chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(vq[i].ev));
            if (vq[i].ev) chk($sformatf("tbl%0d_data", i), rd_data, vq[i].ed);
            chk($sformatf("tbl%0d_err", i), 32'(err_addr), 32'(vq[i].ee));
        end

        // Read in flight when reset hits must never surface.
        step(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd5);
        idle();
        do_reset(2);
        repeat (7) idle();
        do_reset(1);
        wait_clear();

        repeat (600) rand_step();
        repeat (RL + 1) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
